// File: rtl/game_flow_ctrl.sv
// Game sequencer for the VGA maze: lives/level bookkeeping, screen selection and respawn/life-lost events.
// Optional scare overlay on a final-level collision is enabled by defining SCARE_SCREEN_EN.
module game_flow_ctrl #(
  parameter int LIVES        = 3,
  parameter int LEVELS       = 3,
  parameter int HIT_FRAMES   = 60,
  parameter int SCARE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       collision,
  input  logic       goal_reached,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic [1:0] level,
  output logic [1:0] screen_sel,
  output logic       life_lost,
  output logic       respawn,
  output logic       scare_on
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_NEXT  = 3'd3,
    S_OVER  = 3'd4,
`ifdef SCARE_SCREEN_EN
    S_WIN   = 3'd5,
    S_SCARE = 3'd6
`else
    S_WIN   = 3'd5
`endif
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [1:0] LAST_LEVEL = 2'(LEVELS - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
`ifdef SCARE_SCREEN_EN
  localparam logic [7:0] SCARE_LAST = 8'(SCARE_FRAMES - 1);
`endif

  state_t     cur, nxt;
  logic [7:0] frame_cnt, cnt_n;
  logic [1:0] lives_n, level_n, screen_n;
  logic       life_lost_n, respawn_n, scare_n;
  logic       start_q, start_rise;

  assign start_rise = start_btn & ~start_q;
  assign state      = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= S_IDLE;
      lives      <= LIVES_INIT;
      level      <= 2'd0;
      screen_sel <= 2'd0;
      life_lost  <= 1'b0;
      respawn    <= 1'b0;
      scare_on   <= 1'b0;
      frame_cnt  <= 8'd0;
      start_q    <= 1'b0;
    end else begin
      cur        <= nxt;
      lives      <= lives_n;
      level      <= level_n;
      screen_sel <= screen_n;
      life_lost  <= life_lost_n;
      respawn    <= respawn_n;
      scare_on   <= scare_n;
      frame_cnt  <= cnt_n;
      start_q    <= start_btn;
    end
  end

  // PLAY keeps the frame counter cleared so every timed state starts counting from zero,
  // and a tick on the entry edge is never counted.
  always_comb begin
    nxt         = cur;
    lives_n     = lives;
    level_n     = level;
    life_lost_n = 1'b0;
    respawn_n   = 1'b0;
    cnt_n       = frame_cnt;
    case (cur)
      S_IDLE: begin
        if (start_rise) begin
          nxt       = S_PLAY;
          lives_n   = LIVES_INIT;
          level_n   = 2'd0;
          respawn_n = 1'b1;
        end
      end
      S_PLAY: begin
        cnt_n = 8'd0;
        if (collision) begin
          life_lost_n = 1'b1;
`ifdef SCARE_SCREEN_EN
          if (level == LAST_LEVEL) begin
            nxt     = S_SCARE;
            lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          end else
`endif
          if (lives <= 2'd1) begin
            nxt     = S_OVER;
            lives_n = 2'd0;
          end else begin
            nxt     = S_HIT;
            lives_n = lives - 2'd1;
          end
        end else if (goal_reached) begin
          if (level >= LAST_LEVEL) begin
            nxt = S_WIN;
          end else begin
            nxt     = S_NEXT;
            level_n = level + 2'd1;
          end
        end
      end
      S_HIT, S_NEXT: begin
        if (frame_tick) begin
          if (frame_cnt == HIT_LAST) begin
            nxt       = S_PLAY;
            respawn_n = 1'b1;
            cnt_n     = 8'd0;
          end else begin
            cnt_n = frame_cnt + 8'd1;
          end
        end
      end
`ifdef SCARE_SCREEN_EN
      // The life was already charged on entry, so leaving SCARE raises no second pulse.
      S_SCARE: begin
        if (frame_tick) begin
          if (frame_cnt == SCARE_LAST) begin
            nxt     = S_OVER;
            lives_n = 2'd0;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = frame_cnt + 8'd1;
          end
        end
      end
`endif
      S_OVER, S_WIN: begin
        if (start_rise) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    screen_n = 2'd1;
    scare_n  = 1'b0;
    case (nxt)
      S_IDLE:  screen_n = 2'd0;
      S_OVER:  screen_n = 2'd2;
      S_WIN:   screen_n = 2'd3;
      default: screen_n = 2'd1;
    endcase
`ifdef SCARE_SCREEN_EN
    scare_n = (nxt == S_SCARE);
`endif
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus queues every expected output change,
// a negedge monitor pops and compares whenever the DUT outputs change.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       collision = 1'b0;
  logic       goal_reached = 1'b0;
  logic [2:0] state;
  logic [1:0] lives, level, screen_sel;
  logic       life_lost, respawn, scare_on;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] lv;
    logic [1:0] lev;
    logic [1:0] scr;
    logic       ll;
    logic       rs;
    logic       sc;
  } snap_t;

  snap_t exp_q[$];
  snap_t prev_s;
  int    n_cmp = 0;
  int    n_err = 0;

  game_flow_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .collision(collision), .goal_reached(goal_reached), .state(state), .lives(lives),
    .level(level), .screen_sel(screen_sel), .life_lost(life_lost), .respawn(respawn),
    .scare_on(scare_on)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(int st, int lv, int lev, int scr, int ll, int rs, int sc);
    snap_t s;
    s.st = 3'(st); s.lv = 2'(lv); s.lev = 2'(lev); s.scr = 2'(scr);
    s.ll = 1'(ll); s.rs = 1'(rs); s.sc = 1'(sc);
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d lives=%0d level=%0d scr=%0d ll=%0d rs=%0d sc=%0d",
                     s.st, s.lv, s.lev, s.scr, s.ll, s.rs, s.sc);
  endfunction

  function automatic snap_t now_s();
    return {state, lives, level, screen_sel, life_lost, respawn, scare_on};
  endfunction

  task automatic push(int st, int lv, int lev, int scr, int ll, int rs, int sc);
    exp_q.push_back(mk(st, lv, lev, scr, ll, rs, sc));
  endtask

  // Monitor: every observed output change must match the next queued expectation.
  always @(negedge clk) begin
    snap_t cur_s;
    snap_t e;
    cur_s = now_s();
    if (!reset && cur_s != prev_s) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_change actual: %s required: no change", fmt(cur_s));
      end else begin
        e = exp_q.pop_front();
        if (cur_s != e) begin
          n_err++;
          $display("[TB] FAIL seq_%0d actual: %s required: %s", n_cmp, fmt(cur_s), fmt(e));
        end
      end
    end
    prev_s = cur_s;
  end

  task automatic check_output(string name, snap_t e);
    snap_t a;
    a = now_s();
    n_cmp++;
    if (a != e) begin
      n_err++;
      $display("[TB] FAIL %s actual: %s required: %s", name, fmt(a), fmt(e));
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(logic s, logic c, logic g, logic t, int n);
    start_btn    = s;
    collision    = c;
    goal_reached = g;
    frame_tick   = t;
    cyc(n);
  endtask

  task automatic recover(int lv, int lev);
    push(1, lv, lev, 1, 0, 1, 0);
    push(1, lv, lev, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 60);
    apply_stimulus(0, 0, 0, 0, 2);
  endtask

  task automatic press_start_to_play();
    push(1, 3, 0, 1, 0, 1, 0);
    push(1, 3, 0, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual: still running required: finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc(2);
    check_output("reset_state", mk(0, 3, 0, 0, 0, 0, 0));
    reset = 1'b0;
    cyc(1);

    press_start_to_play();

    // Held collision costs one life; extra collisions in HIT are ignored.
    push(2, 2, 0, 1, 1, 0, 0);
    push(2, 2, 0, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 100);
    check_output("hit_hold", mk(2, 2, 0, 1, 0, 0, 0));
    recover(2, 0);

    push(2, 1, 0, 1, 1, 0, 0);
    push(2, 1, 0, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);
    recover(1, 0);

    push(4, 0, 0, 2, 1, 0, 0);
    push(4, 0, 0, 2, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 2);
    push(0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 2);

    press_start_to_play();
    push(3, 3, 1, 1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1);
    recover(3, 1);

    // Tick on the entry edge into NEXT must not be counted.
    push(3, 3, 2, 1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 1, 59);
    check_output("next_after_59", mk(3, 3, 2, 1, 0, 0, 0));
    push(1, 3, 2, 1, 0, 1, 0);
    push(1, 3, 2, 1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 2);

    push(5, 3, 2, 3, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 2);
    push(0, 3, 2, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 2);

    // Collision wins over goal; then reset mid-HIT with the counter at 30.
    press_start_to_play();
    push(2, 2, 0, 1, 1, 0, 0);
    push(2, 2, 0, 1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 0, 1);
    apply_stimulus(0, 0, 0, 1, 30);
    frame_tick = 1'b0;
    reset = 1'b1;
    #1;
    check_output("reset_mid_hit", mk(0, 3, 0, 0, 0, 0, 0));
    cyc(2);
    reset = 1'b0;
    cyc(1);

    press_start_to_play();
    push(3, 3, 1, 1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1);
    recover(3, 1);
    push(3, 3, 2, 1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 1);
    recover(3, 2);

`ifdef SCARE_SCREEN_EN
    push(6, 2, 2, 1, 1, 0, 1);
    push(6, 2, 2, 1, 0, 0, 1);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("scare_active", mk(6, 2, 2, 1, 0, 0, 1));
    push(4, 0, 2, 2, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 120);
    apply_stimulus(0, 0, 0, 0, 2);
`else
    push(2, 2, 2, 1, 1, 0, 0);
    push(2, 2, 2, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("final_level_hit", mk(2, 2, 2, 1, 0, 0, 0));
    recover(2, 2);
`endif

    cyc(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL queue_drained actual: %0d pending required: 0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the VGA maze game. Owns the lives and level state, decides which screen the pixel mux shows, and pulses respawn and life-lost events toward the cursor and HUD generators. It sits between the collision/goal detectors and the screen generators. It replaces free-running edge-clocked counting with a single synchronous FSM on `clk`.

## Interface
- `LIVES`, default 3: starting lives; 1..3.
- `LEVELS`, default 3: number of maze levels; 1..4.
- `HIT_FRAMES`, default 60: frames spent in HIT and NEXT; 1..255.
- `SCARE_FRAMES`, default 120: frames spent in SCARE; 1..255.
- `clk`  in  1  system/pixel clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per VGA frame.
- `start_btn`  in  1  debounced start button, level; synchronous to `clk`.
- `collision`  in  1  cursor overlaps a wall this cycle.
- `goal_reached`  in  1  cursor overlaps the level goal this cycle.
- `state`  out  3  IDLE=0, PLAY=1, HIT=2, NEXT=3, OVER=4, WIN=5, SCARE=6.
- `lives`  out  2  remaining lives.
- `level`  out  2  current level index, 0-based.
- `screen_sel`  out  2  0=title, 1=maze, 2=game over, 3=win.
- `life_lost`  out  1  one-cycle pulse per life lost.
- `respawn`  out  1  one-cycle pulse; cursor returns to the level start.
- `scare_on`  out  1  overlay the scare image.

## Operation
- `start_rise` = `start_btn` & ~`start_q`. `start_q` is a registered copy of `start_btn`; its reset value is 0.
- **IDLE:** on `start_rise`, load `lives`=LIVES and `level`=0, pulse `respawn`, go to PLAY.
- **PLAY:** `collision` has priority over `goal_reached` when both are high in the same cycle.
  - On `collision`, pulse `life_lost`.
    - If `lives`==1: set `lives`=0 and go to OVER.
    - Otherwise: decrement `lives` and go to HIT.
  - On `goal_reached` with `level`==LEVELS-1, go to WIN.
  - On `goal_reached` otherwise, increment `level` and go to NEXT.
  - `start_rise` is ignored.
- **HIT and NEXT:** the frame counter clears on entry and increments on each `frame_tick`.
  - On a `frame_tick` with count==HIT_FRAMES-1: pulse `respawn` and go to PLAY.
  - `collision`, `goal_reached` and `start_rise` are ignored in these states.
- **SCARE:** same counting, using SCARE_FRAMES. At the end, set `lives`=0 and go to OVER. Pulse `life_lost` only if it was not already pulsed.
- **OVER and WIN:** on `start_rise`, go to IDLE. `lives` and `level` hold their values.
- `screen_sel`: IDLE=0, PLAY/HIT/NEXT/SCARE=1, OVER=2, WIN=3.
- Undefined state encodings (7) go to IDLE on the next clock.
- Arithmetic: `lives` never wraps below 0. `level` never exceeds LEVELS-1. The frame counter is 8 bits.

## Timing
- Reset values of all outputs:
  - `state`=IDLE, `lives`=LIVES, `level`=0, `screen_sel`=0.
  - `life_lost`=0, `respawn`=0, `scare_on`=0.
  - The frame counter resets to 0.
- All outputs are registered. Each changes on the same edge as the state transition that causes it, which is the edge after the input was sampled high. Latency is 1 clock.
- `life_lost` and `respawn` are high for exactly one clock per event.
- `collision` held high for many cycles costs only one life, because PLAY is left on the first cycle.
- Frame counting: the state is left on the edge that samples the final `frame_tick`.
- A `frame_tick` coincident with the transition into HIT/NEXT/SCARE is not counted.
- A reset asserted in any state returns all outputs to their reset values immediately.

## Configuration
- `SCARE_SCREEN_EN` defined:
  - A `collision` in PLAY with `level`==LEVELS-1 goes to SCARE instead of HIT/OVER, regardless of lives remaining.
  - `life_lost` pulses on entry to SCARE, and `lives` is decremented on entry.
  - `scare_on`=1 throughout SCARE.
- `SCARE_SCREEN_EN` undefined:
  - The SCARE state is absent.
  - `scare_on` is constant 0.
  - A final-level collision is handled like any other collision.

## Test plan
- Reset → `state`=0, `lives`=3, `level`=0, `screen_sel`=0. Then `start_btn` rises → next clock `state`=1, one `respawn` pulse, `screen_sel`=1.
- In PLAY, `collision` held for 100 cycles → one `life_lost` pulse, `lives`=2, `state`=2. After 60 `frame_tick`s → `state`=1 with one `respawn` pulse. Extra collisions during HIT → no change.
- Three separate collisions on level 0 → `lives` goes 2, 1, 0; the third collision gives `state`=4 and `screen_sel`=2. `start_rise` → `state`=0.
- `goal_reached` on levels 0 and 1 → `level` goes 1, then 2, via NEXT. `goal_reached` on level 2 → `state`=5, `screen_sel`=3. `collision` and `goal_reached` high in the same cycle → collision path taken.
- With `SCARE_SCREEN_EN` and `lives`=3 on level 2, `collision` → `state`=6 and `scare_on`=1 for 120 frames, then `state`=4 with `lives`=0. Without the macro → `state`=2.
- `reset` asserted mid-HIT with the frame counter at 30 → all outputs at reset values at once. Next `start_rise` → PLAY with `lives`=3.
